// File: rtl/alu_result_pkg.sv
// Shared definitions for the ALU result buffer: default width, path tags, entry layout.
// Optional per-path push statistics are enabled with the ALU_RESULT_STATS_EN macro.
package alu_result_pkg;

  localparam int ALU_BITS_SIZE = 64;

  localparam logic PATH_VEC1 = 1'b1;
  localparam logic PATH_VEC2 = 1'b0;

  // Queue entry layout at the default width: tag sits above the data word.
  typedef struct packed {
    logic                     tag;
    logic [ALU_BITS_SIZE-1:0] data;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and an occupancy count.
// Storage is not reset; only pointers and occupancy are cleared.
module alu_result_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, never on the pop side.
  assign push_ready = (cnt != FULL_LVL);
  assign pop_valid  = (cnt != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign level      = cnt;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures the driven half of the ALU demux output, tags it with its path and queues it for writeback.
// Define ALU_RESULT_STATS_EN to add saturating per-path push counters (path1Count/path2Count).
module alu_result_buffer
  import alu_result_pkg::*;
#(
  parameter int BITS_SIZE = ALU_BITS_SIZE,
  parameter int DEPTH     = 4
`ifdef ALU_RESULT_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS_SIZE-1:0]   inputVector1,
  input  logic [BITS_SIZE-1:0]   inputVector2,
  input  logic                   aluOpSel,
  input  logic                   inValid,
  output logic                   inReady,
  output logic [BITS_SIZE-1:0]   outData,
  output logic                   outPath,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(DEPTH):0] level
`ifdef ALU_RESULT_STATS_EN
  , output logic [CNT_W-1:0]     path1Count
  , output logic [CNT_W-1:0]     path2Count
`endif
);

  logic [BITS_SIZE:0] cap_entry;
  logic [BITS_SIZE:0] head_entry;
  logic               cap_tag;

  // Only the vector the demux is driving is looked at; the high-Z side never reaches the queue.
  assign cap_tag   = aluOpSel ? PATH_VEC1 : PATH_VEC2;
  assign cap_entry = aluOpSel ? {cap_tag, inputVector1} : {cap_tag, inputVector2};

  alu_result_fifo #(
    .WIDTH (BITS_SIZE + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (inValid),
    .push_ready (inReady),
    .push_data  (cap_entry),
    .pop_valid  (outValid),
    .pop_ready  (outReady),
    .pop_data   (head_entry),
    .level      (level)
  );

  assign outData = head_entry[BITS_SIZE-1:0];
  assign outPath = head_entry[BITS_SIZE];

`ifdef ALU_RESULT_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic push;
  assign push = inValid && inReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      path1Count <= '0;
      path2Count <= '0;
    end else if (push) begin
      if (cap_tag == PATH_VEC1) path1Count <= sat_inc(path1Count);
      else                      path2Count <= sat_inc(path2Count);
    end
  end
`else
  // Statistics disabled: no counters or ports are built.
`endif

endmodule
